pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Generic parametrised pipeline stage register; successor to the fixed-field inter-stage latches (e.g. EX->MEM).
//  Carries control bits, NUM_LANES data words and a destination register address, using a valid/ready handshake.
//  A 2-entry output+skid buffer gives full throughput with a registered ready_o.
//  Adds flush (bubble insertion), a global hold (stall_i) and a saturating stall counter for performance monitoring.
// PARAMETERS
//  CTRL_W      4   width of control bundle (e.g. RegWrite, MemReg, MemRead, MemWrite)
//  DATA_W      32  width of one data lane
//  NUM_LANES   2   number of data lanes (e.g. ALU result, store data)
//  ADDR_W      5   destination register address width
//  STALL_CNT_W 16  width of the stall_cnt_o counter
// PORTS
//  clk_i        in   1                   clock; all state updates on rising edge
//  rst_i        in   1                   reset; synchronous, active-low
//  flush_i      in   1                   discard all held entries; insert bubble
//  stall_i      in   1                   hold every register; no enqueue, no dequeue
//  valid_i      in   1                   upstream entry valid
//  ready_o      out  1                   stage can accept an entry this cycle
//  ctrl_i       in   CTRL_W              control bundle in
//  data_i       in   NUM_LANES*DATA_W    data lanes in; lane k = [k*DATA_W +: DATA_W]
//  rd_addr_i    in   ADDR_W              destination register address in
//  valid_o      out  1                   output entry valid
//  ready_i      in   1                   downstream accepts
//  ctrl_o       out  CTRL_W              control bundle out; forced 0 when valid_o=0
//  data_o       out  NUM_LANES*DATA_W    data lanes out
//  rd_addr_o    out  ADDR_W              destination register address out
//  stall_cnt_o  out  STALL_CNT_W         saturating count of stalled cycles
// BEHAVIOUR
//  Storage: output register (OUT) and skid register (SKID), each with its own valid bit.
//  ready_o  = !skid_v && !stall_i. ready_o is combinational only through stall_i.
//  fire_in  = valid_i && ready_o.  fire_out = valid_o && ready_i && !stall_i.
//  valid_o  = out_v (registered).
//  Priority at each edge: reset > flush > stall > normal.
//  Reset (rst_i=0 at edge):
//   - out_v = skid_v = 0
//   - ctrl_o, data_o, rd_addr_o = 0
//   - stall_cnt_o = 0
//  Flush: out_v = skid_v = 0; ctrl_o, data_o, rd_addr_o = 0.
//   - A concurrent valid_i is dropped; flush with stall_i=1 still flushes.
//   - stall_cnt_o is not incremented in a flush cycle.
//  Stall (stall_i=1, no flush): all registers hold. stall_cnt_o += 1, saturating at 2^STALL_CNT_W-1.
//  Normal operation:
//   - OUT loads when (!out_v || fire_out): from SKID if skid_v (skid_v <= 0, or <= fire_in if refilled); else from input if fire_in.
//   - OUT otherwise: out_v <= 0 if fire_out with nothing to load.
//   - out_v=1, !fire_out, fire_in: entry goes to SKID, skid_v <= 1.
//   - Order is preserved: SKID always drains before any new input reaches OUT.
//  Latency: 1 cycle valid_i->valid_o when empty. Throughput: 1 entry/cycle with ready_i=1.
//  ctrl_o reads 0 whenever out_v=0, so bubbles can never assert RegWrite or MemWrite downstream.
//   - data_o and rd_addr_o hold their last value on a bubble (they are zeroed only on flush or reset).
//  Overflow cannot occur: ready_o=0 while SKID is full. Upstream must hold valid_i and its payload until fire_in.
// TESTING
//  1 Reset: rst_i=0 for 2 cycles with valid_i=1 -> valid_o=0, ctrl_o=0, data_o=0, rd_addr_o=0, stall_cnt_o=0, ready_o=1.
//  2 Stream: ready_i=1, 4 back-to-back entries (ctrl=4'b1010, rd=1..4, lane0=0x10..0x13)
//     -> each appears 1 cycle later, in order, no gaps.
//  3 Backpressure: ready_i=0 while sending entries A,B
//     -> A held on output; B in SKID; ready_o=0.
//     Then ready_i=1 -> A, then B, then next input on consecutive cycles.
//  4 Stall: stall_i=1 for 3 cycles with valid_o=1, ready_i=1
//     -> outputs frozen, ready_o=0, no transfer, stall_cnt_o += 3.
//  5 Flush: OUT and SKID full, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ctrl_o=0, ready_o=1; input entry lost.
//  6 Saturation: STALL_CNT_W=4, stall_i=1 for 20 cycles -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage register with a valid/ready handshake. It carries a
//   control bundle, NUM_LANES data words and a destination register address.
//   A two-entry buffer gives full throughput while keeping ready_o registered.
//   The two entries are the output register (OUT) and a skid register (SKID).
//   The stage also provides a flush that inserts a bubble, a global hold
//   (stall_i), and a saturating stall counter for performance monitoring.
//
// Ports
//   clk_i        in   clock; all state updates on the rising edge
//   rst_i        in   synchronous, active-low reset
//   flush_i      in   discard all held entries and insert a bubble
//   stall_i      in   hold every register; no enqueue and no dequeue
//   valid_i      in   upstream entry valid
//   ready_o      out  stage can accept an entry this cycle
//   ctrl_i       in   control bundle in
//   data_i       in   data lanes in; lane k = [k*DATA_W +: DATA_W]
//   rd_addr_i    in   destination register address in
//   valid_o      out  output entry valid
//   ready_i      in   downstream accepts
//   ctrl_o       out  control bundle out; reads 0 when valid_o = 0
//   data_o       out  data lanes out
//   rd_addr_o    out  destination register address out
//   stall_cnt_o  out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int CTRL_W      = 4,
  parameter int DATA_W      = 32,
  parameter int NUM_LANES   = 2,
  parameter int ADDR_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        stall_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [CTRL_W-1:0]           ctrl_i,
  input  logic [NUM_LANES*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [CTRL_W-1:0]           ctrl_o,
  output logic [NUM_LANES*DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0]           rd_addr_o,
  output logic [STALL_CNT_W-1:0]      stall_cnt_o
);

  typedef struct packed {
    logic [CTRL_W-1:0]           ctrl;
    logic [NUM_LANES*DATA_W-1:0] data;
    logic [ADDR_W-1:0]           addr;
  } entry_t;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  entry_t                 in_entry;
  entry_t                 out_q;
  entry_t                 skid_q;
  logic                   out_v;
  logic                   skid_v;
  logic                   fire_in;
  logic                   fire_out;
  logic                   load_out;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign in_entry = '{ctrl: ctrl_i, data: data_i, addr: rd_addr_i};

  // ready_o depends on registered state plus stall_i only. It never depends
  // on ready_i, which keeps long combinational paths out of the handshake.
  assign ready_o  = !skid_v && !stall_i;
  assign fire_in  = valid_i && ready_o;
  assign fire_out = out_v && ready_i && !stall_i;
  // OUT may be rewritten when it is empty or when its entry leaves this cycle.
  assign load_out = !out_v || fire_out;

  always_ff @(posedge clk_i) begin
    // NOTE: the payload registers are cleared as well as the valid bits,
    // because data_o and rd_addr_o must read zero after reset and after a flush.
    if (!rst_i) begin
      out_v     <= 1'b0;
      skid_v    <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
    end else if (flush_i) begin
      // A flush overrides a stall, and a flush cycle is not counted as stalled.
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (stall_i) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end else if (load_out) begin
      if (skid_v) begin
        // SKID drains first, which preserves order. ready_o is low while SKID
        // is full, so fire_in is 0 here in practice. The refill path is kept
        // so the update stays self-consistent.
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= fire_in;
        if (fire_in) begin
          skid_q <= in_entry;
        end
      end else if (fire_in) begin
        out_q <= in_entry;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (fire_in) begin
      // OUT is occupied and blocked, so the accepted entry goes to SKID.
      skid_q <= in_entry;
      skid_v <= 1'b1;
    end
  end

  assign valid_o     = out_v;
  // Bubbles must never assert RegWrite or MemWrite downstream.
  // data_o and rd_addr_o simply hold their last value.
  assign ctrl_o      = out_v ? out_q.ctrl : '0;
  assign data_o      = out_q.data;
  assign rd_addr_o   = out_q.addr;
  assign stall_cnt_o = stall_cnt;

endmodule
